alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 167 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 501 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter giving two requesters shared access to an 8-bit ALU.
// One operation is in flight at a time: IDLE (grant) -> EXEC (settle) -> RESP (hold result).
module alu_arbiter #(
  parameter  int unsigned ALU_LAT = 1,
  localparam int unsigned OP_W    = 4,
  localparam int unsigned D_W     = 8,
  localparam int unsigned R_W     = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [OP_W-1:0] req0_opcode,
  input  logic [D_W-1:0]  req0_a,
  input  logic [D_W-1:0]  req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [OP_W-1:0] req1_opcode,
  input  logic [D_W-1:0]  req1_a,
  input  logic [D_W-1:0]  req1_b,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [R_W-1:0]  rsp_result,
  output logic            rsp_flagC,
  output logic            rsp_flagZ,
  output logic [OP_W-1:0] alu_opcode,
  output logic [D_W-1:0]  alu_operand1,
  output logic [D_W-1:0]  alu_operand2,
  input  logic [R_W-1:0]  alu_result,
  input  logic            alu_flagC,
  input  logic            alu_flagZ
);

  localparam int unsigned   CNT_W  = 4;
  localparam logic [OP_W-1:0] OP_DIV = OP_W'(3);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_e;

  typedef struct packed {
    logic [OP_W-1:0] opcode;
    logic [D_W-1:0]  a;
    logic [D_W-1:0]  b;
  } alu_req_t;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             owner_q, owner_d;
  alu_req_t         op_q, op_d;
  logic [R_W-1:0]   res_q, res_d;
  logic             flag_c_q, flag_c_d;
  logic             flag_z_q, flag_z_d;
  logic             rsp0_valid_q, rsp0_valid_d;
  logic             rsp1_valid_q, rsp1_valid_d;
  logic             gnt0_c, gnt1_c;
  alu_req_t         req0_pl, req1_pl;

  assign req0_pl = {req0_opcode, req0_a, req0_b};
  assign req1_pl = {req1_opcode, req1_a, req1_b};

  // Grant is combinational in IDLE; last_q=1 means requester 1 was served last.
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (rst_n && (state_q == IDLE)) begin
      if (req0_valid && req1_valid) begin
        gnt0_c = last_q;
        gnt1_c = !last_q;
      end else begin
        gnt0_c = req0_valid;
        gnt1_c = req1_valid;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    owner_d      = owner_q;
    op_d         = op_q;
    res_d        = res_q;
    flag_c_d     = flag_c_q;
    flag_z_d     = flag_z_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
    case (state_q)
      IDLE: begin
        if (gnt0_c || gnt1_c) begin
          op_d    = gnt1_c ? req1_pl : req0_pl;
          cnt_d   = CNT_W'(ALU_LAT);
          owner_d = gnt1_c;
          last_d  = gnt1_c;
          state_d = EXEC;
        end
      end
      EXEC: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          // Divide by zero is answered locally with a saturated result.
          if ((op_q.opcode == OP_DIV) && (op_q.b == D_W'(0))) begin
            res_d    = {R_W{1'b1}};
            flag_c_d = 1'b1;
            flag_z_d = 1'b0;
          end else begin
            res_d    = alu_result;
            flag_c_d = alu_flagC;
            flag_z_d = alu_flagZ;
          end
          rsp0_valid_d = !owner_q;
          rsp1_valid_d = owner_q;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (owner_q ? rsp1_ready : rsp0_ready) begin
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_q       <= 1'b1;
      owner_q      <= 1'b0;
      op_q         <= '0;
      res_q        <= '0;
      flag_c_q     <= 1'b0;
      flag_z_q     <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      owner_q      <= owner_d;
      op_q         <= op_d;
      res_q        <= res_d;
      flag_c_q     <= flag_c_d;
      flag_z_q     <= flag_z_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
    end
  end

  assign req0_ready   = gnt0_c;
  assign req1_ready   = gnt1_c;
  assign rsp0_valid   = rsp0_valid_q;
  assign rsp1_valid   = rsp1_valid_q;
  assign rsp_result   = res_q;
  assign rsp_flagC    = flag_c_q;
  assign rsp_flagZ    = flag_z_q;
  assign alu_opcode   = op_q.opcode;
  assign alu_operand1 = op_q.a;
  assign alu_operand2 = op_q.b;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: instance 0 uses ALU_LAT=1 with a scoreboard monitor,
// instance 1 uses ALU_LAT=4 for mid-transaction reset and long-latency timing.
module tb_alu_arbiter;

  typedef struct packed {
    logic        owner;
    logic        c;
    logic        z;
    logic [15:0] r;
  } exp_t;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } pay_t;

  logic        clk;
  logic [1:0]  rst_n;
  logic [1:0]  req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0]  rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [1:0]  rsp_flag_c, rsp_flag_z, alu_flag_c, alu_flag_z;
  logic [3:0]  req0_opcode [2];
  logic [3:0]  req1_opcode [2];
  logic [7:0]  req0_a [2];
  logic [7:0]  req0_b [2];
  logic [7:0]  req1_a [2];
  logic [7:0]  req1_b [2];
  logic [15:0] rsp_result [2];
  logic [3:0]  alu_opcode [2];
  logic [7:0]  alu_operand1 [2];
  logic [7:0]  alu_operand2 [2];
  logic [15:0] alu_result [2];

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];

  // Reference 8-bit ALU: {carry, zero, result}. Divide by zero returns junk on purpose.
  function automatic logic [17:0] alu_f(input logic [3:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
    logic [15:0] r;
    logic        c;
    c = 1'b0;
    case (op)
      4'd0:    begin r = 16'(a) + 16'(b); c = r[8]; end
      4'd1:    begin r = 16'(a) - 16'(b); c = (a < b); end
      4'd2:    r = 16'(a) * 16'(b);
      4'd3:    r = (b == 8'd0) ? 16'h1234 : 16'(a / b);
      4'd15:   r = {15'd0, (a == b)};
      default: r = {8'd0, a ^ b};
    endcase
    return {c, (r == 16'd0), r};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [19:0] prev;
    logic [4:0]  age;
    initial begin
      prev = '0;
      age  = 5'd31;
    end
    // ALU output is junk until it has seen stable operands for ALU_LAT cycles.
    always @(negedge clk) begin
      if ({alu_opcode[g], alu_operand1[g], alu_operand2[g]} != prev) begin
        prev = {alu_opcode[g], alu_operand1[g], alu_operand2[g]};
        age  = 5'd1;
      end else if (age != 5'd31) begin
        age = age + 5'd1;
      end
    end
    assign {alu_flag_c[g], alu_flag_z[g], alu_result[g]} =
      (age >= ((g == 0) ? 5'd1 : 5'd4)) ?
        alu_f(alu_opcode[g], alu_operand1[g], alu_operand2[g]) : {2'b11, 16'hDEAD};

    alu_arbiter #(.ALU_LAT((g == 0) ? 1 : 4)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n[g]),
      .req0_valid  (req0_valid[g]),
      .req0_ready  (req0_ready[g]),
      .req0_opcode (req0_opcode[g]),
      .req0_a      (req0_a[g]),
      .req0_b      (req0_b[g]),
      .req1_valid  (req1_valid[g]),
      .req1_ready  (req1_ready[g]),
      .req1_opcode (req1_opcode[g]),
      .req1_a      (req1_a[g]),
      .req1_b      (req1_b[g]),
      .rsp0_valid  (rsp0_valid[g]),
      .rsp0_ready  (rsp0_ready[g]),
      .rsp1_valid  (rsp1_valid[g]),
      .rsp1_ready  (rsp1_ready[g]),
      .rsp_result  (rsp_result[g]),
      .rsp_flagC   (rsp_flag_c[g]),
      .rsp_flagZ   (rsp_flag_z[g]),
      .alu_opcode  (alu_opcode[g]),
      .alu_operand1(alu_operand1[g]),
      .alu_operand2(alu_operand2[g]),
      .alu_result  (alu_result[g]),
      .alu_flagC   (alu_flag_c[g]),
      .alu_flagZ   (alu_flag_z[g])
    );
  end

  always #5 clk = ~clk;

  // Scoreboard for instance 0: every consumed response is popped and compared.
  always @(negedge clk) begin
    exp_t e, got;
    if (rst_n[0] && (rsp0_valid[0] || rsp1_valid[0])) begin
      n_tests++;
      if (rsp0_valid[0] && rsp1_valid[0]) begin
        n_fail++;
        $display("FAIL rsp_overlap: rsp0_valid=%b rsp1_valid=%b, required one-hot",
                 rsp0_valid[0], rsp1_valid[0]);
      end
      if ((rsp0_valid[0] && rsp0_ready[0]) || (rsp1_valid[0] && rsp1_ready[0])) begin
        n_tests++;
        got = {rsp1_valid[0], rsp_flag_c[0], rsp_flag_z[0], rsp_result[0]};
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got owner=%0d res=%h with empty scoreboard",
                   got.owner, got.r);
        end else begin
          e = sb_q.pop_front();
          if (got !== e) begin
            n_fail++;
            $display("FAIL sb_rsp: got owner=%0d res=%h C=%b Z=%b, required owner=%0d res=%h C=%b Z=%b",
                     got.owner, got.r, got.c, got.z, e.owner, e.r, e.c, e.z);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n         = 2'b00;
    req0_valid[0] = 1'b1;
    req1_valid[0] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({req0_ready[0], req1_ready[0], rsp0_valid[0], rsp1_valid[0]} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_hs: got rdy/vld=%b, required 0000",
               {req0_ready[0], req1_ready[0], rsp0_valid[0], rsp1_valid[0]});
    end
    n_tests++;
    if ({alu_opcode[0], alu_operand1[0], alu_operand2[0]} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_alu: got %h, required 0",
               {alu_opcode[0], alu_operand1[0], alu_operand2[0]});
    end
    n_tests++;
    if ({rsp_result[0], rsp_flag_c[0], rsp_flag_z[0]} !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_rsp: got %h, required 0",
               {rsp_result[0], rsp_flag_c[0], rsp_flag_z[0]});
    end
    req0_valid[0] = 1'b0;
    req1_valid[0] = 1'b0;
    tick();
    rst_n = 2'b11;
  endtask

  task automatic test_add();
    req0_opcode[0] = 4'd0; req0_a[0] = 8'hFF; req0_b[0] = 8'h01;
    req0_valid[0]  = 1'b1;
    sb_q.push_back({1'b0, 1'b1, 1'b0, 16'h0100});
    @(negedge clk);
    n_tests++;
    if (req0_ready[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL add_ready: got %b, required 1 on first edge after reset", req0_ready[0]);
    end
    tick();
    req0_valid[0] = 1'b0;
    @(negedge clk);
    n_tests++;
    if (rsp0_valid[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL add_exec: rsp0_valid=%b, required 0 during EXEC", rsp0_valid[0]);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if ({rsp0_valid[0], rsp1_valid[0]} !== 2'b10) begin
      n_fail++;
      $display("FAIL add_latency: rsp0/rsp1 valid=%b, required 10", {rsp0_valid[0], rsp1_valid[0]});
    end
    tick();
    @(negedge clk);
    n_tests++;
    if ({rsp0_valid[0], rsp_result[0]} !== {1'b0, 16'h0100}) begin
      n_fail++;
      $display("FAIL add_release: valid=%b res=%h, required 0 / 0100",
               rsp0_valid[0], rsp_result[0]);
    end
    tick();
  endtask

  task automatic test_contention();
    int  i;
    logic got;
    rst_n[0] = 1'b0;
    #2;
    rst_n[0] = 1'b1;
    req0_opcode[0] = 4'd2; req0_a[0] = 8'h10; req0_b[0] = 8'h10;
    req1_opcode[0] = 4'd1; req1_a[0] = 8'h05; req1_b[0] = 8'h05;
    req0_valid[0]  = 1'b1;
    req1_valid[0]  = 1'b1;
    sb_q.push_back({1'b0, 1'b0, 1'b0, 16'h0100});
    sb_q.push_back({1'b1, 1'b0, 1'b1, 16'h0000});
    @(negedge clk);
    n_tests++;
    if ({req1_ready[0], req0_ready[0]} !== 2'b01) begin
      n_fail++;
      $display("FAIL contend_first: ready1/0=%b, required 01", {req1_ready[0], req0_ready[0]});
    end
    tick();
    req0_valid[0] = 1'b0;
    got = 1'b0;
    for (i = 0; i < 12; i++) begin
      @(negedge clk);
      if (req1_ready[0]) begin
        got = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!got || (i != 2)) begin
      n_fail++;
      $display("FAIL contend_second: req1 grant seen=%b after %0d cycles, required 1 after 2", got, i);
    end
    tick();
    req1_valid[0] = 1'b0;
    for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(negedge clk);
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL contend_drain: %0d responses outstanding, required 0", sb_q.size());
    end
    tick();
  endtask

  task automatic test_round_robin();
    pay_t pay [6];
    logic [17:0] r;
    int i0, i1, nacc;
    logic acc0, acc1;
    logic [3:0] ops [4];
    ops[0] = 4'd0; ops[1] = 4'd1; ops[2] = 4'd2; ops[3] = 4'd15;
    for (int k = 0; k < 6; k++) begin
      pay[k].op = ops[$urandom_range(0, 3)];
      pay[k].a  = 8'($urandom);
      pay[k].b  = 8'($urandom);
      r = alu_f(pay[k].op, pay[k].a, pay[k].b);
      sb_q.push_back({1'(k % 2), r});
    end
    i0 = 0; i1 = 1; nacc = 0;
    {req0_opcode[0], req0_a[0], req0_b[0]} = pay[0];
    {req1_opcode[0], req1_a[0], req1_b[0]} = pay[1];
    req0_valid[0] = 1'b1;
    req1_valid[0] = 1'b1;
    for (int cyc = 0; cyc < 60 && nacc < 6; cyc++) begin
      @(negedge clk);
      acc0 = req0_ready[0];
      acc1 = req1_ready[0];
      if (acc0 || acc1) begin
        n_tests++;
        if ((acc0 && acc1) || (acc1 != 1'(nacc % 2))) begin
          n_fail++;
          $display("FAIL rr_grant: grant %0d ready1/0=%b%b, required requester %0d",
                   nacc, acc1, acc0, nacc % 2);
        end
        nacc++;
      end
      tick();
      if (acc0) begin
        i0 += 2;
        if (i0 < 6) {req0_opcode[0], req0_a[0], req0_b[0]} = pay[i0];
        else req0_valid[0] = 1'b0;
      end
      if (acc1) begin
        i1 += 2;
        if (i1 < 6) {req1_opcode[0], req1_a[0], req1_b[0]} = pay[i1];
        else req1_valid[0] = 1'b0;
      end
    end
    n_tests++;
    if (nacc != 6) begin
      n_fail++;
      $display("FAIL rr_count: %0d grants, required 6", nacc);
    end
    req0_valid[0] = 1'b0;
    req1_valid[0] = 1'b0;
    for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(negedge clk);
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL rr_drain: %0d responses outstanding, required 0", sb_q.size());
    end
    tick();
  endtask

  task automatic test_div_zero();
    req1_opcode[0] = 4'd3; req1_a[0] = 8'h20; req1_b[0] = 8'h00;
    req1_valid[0]  = 1'b1;
    sb_q.push_back({1'b1, 1'b1, 1'b0, 16'hFFFF});
    @(negedge clk);
    n_tests++;
    if (req1_ready[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL div_ready: got %b, required 1", req1_ready[0]);
    end
    tick();
    req1_valid[0] = 1'b0;
    @(negedge clk);
    n_tests++;
    if (rsp1_valid[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL div_exec: rsp1_valid=%b, required 0", rsp1_valid[0]);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if ({rsp1_valid[0], rsp0_valid[0]} !== 2'b10) begin
      n_fail++;
      $display("FAIL div_latency: rsp1/rsp0 valid=%b, required 10", {rsp1_valid[0], rsp0_valid[0]});
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic got;
    rsp0_ready[0]  = 1'b0;
    req0_opcode[0] = 4'd0; req0_a[0] = 8'h03; req0_b[0] = 8'h04;
    req0_valid[0]  = 1'b1;
    sb_q.push_back({1'b0, 1'b0, 1'b0, 16'h0007});
    sb_q.push_back({1'b1, 1'b0, 1'b0, 16'h0001});
    @(negedge clk);
    n_tests++;
    if (req0_ready[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_accept: req0_ready=%b, required 1", req0_ready[0]);
    end
    tick();
    req0_valid[0]  = 1'b0;
    req1_opcode[0] = 4'd15; req1_a[0] = 8'h09; req1_b[0] = 8'h09;
    req1_valid[0]  = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp0_valid[0]) begin
        got = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL bp_rsp: rsp0_valid never seen, required within 10 cycles");
    end
    for (int k = 0; k < 10; k++) begin
      n_tests++;
      if ({rsp0_valid[0], req1_ready[0], rsp_result[0]} !== {2'b10, 16'h0007}) begin
        n_fail++;
        $display("FAIL bp_hold: cycle %0d vld=%b rdy1=%b res=%h, required 1/0/0007",
                 k, rsp0_valid[0], req1_ready[0], rsp_result[0]);
      end
      @(negedge clk);
    end
    tick();
    rsp0_ready[0] = 1'b1;
    @(negedge clk);
    n_tests++;
    if (req1_ready[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_resp_ready: req1_ready=%b in RESP, required 0", req1_ready[0]);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if (req1_ready[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_next_accept: req1_ready=%b in IDLE, required 1", req1_ready[0]);
    end
    tick();
    req1_valid[0] = 1'b0;
    for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(negedge clk);
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_drain: %0d responses outstanding, required 0", sb_q.size());
    end
    tick();
  endtask

  task automatic test_reset_mid_exec();
    logic seen;
    logic got;
    int   i;
    req0_opcode[1] = 4'd0; req0_a[1] = 8'h10; req0_b[1] = 8'h20;
    req0_valid[1]  = 1'b1;
    @(negedge clk);
    n_tests++;
    if (req0_ready[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL rstx_accept: req0_ready=%b, required 1", req0_ready[1]);
    end
    tick();
    req0_valid[1] = 1'b0;
    tick();
    rst_n[1] = 1'b0;
    #1;
    n_tests++;
    if ({alu_opcode[1], alu_operand1[1], alu_operand2[1], rsp_result[1], rsp_flag_c[1],
         rsp_flag_z[1], rsp0_valid[1], rsp1_valid[1], req0_ready[1], req1_ready[1]} !== 42'h0) begin
      n_fail++;
      $display("FAIL rstx_outputs: alu=%h res=%h C=%b Z=%b vld=%b%b, required all 0",
               {alu_opcode[1], alu_operand1[1], alu_operand2[1]}, rsp_result[1],
               rsp_flag_c[1], rsp_flag_z[1], rsp0_valid[1], rsp1_valid[1]);
    end
    tick();
    rst_n[1] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      seen |= rsp0_valid[1] | rsp1_valid[1];
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL rstx_no_rsp: response seen=%b after reset, required 0", seen);
    end
    tick();
    req1_opcode[1] = 4'd0; req1_a[1] = 8'h30; req1_b[1] = 8'h05;
    req1_valid[1]  = 1'b1;
    @(negedge clk);
    n_tests++;
    if (req1_ready[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL rstx_next_accept: req1_ready=%b, required 1", req1_ready[1]);
    end
    tick();
    req1_valid[1] = 1'b0;
    got = 1'b0;
    for (i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp1_valid[1]) begin
        got = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!got || (i != 4)) begin
      n_fail++;
      $display("FAIL rstx_latency: rsp1_valid seen=%b after %0d cycles, required 1 after 4", got, i);
    end
    n_tests++;
    if ({rsp0_valid[1], rsp_flag_c[1], rsp_flag_z[1], rsp_result[1]} !== {3'b000, 16'h0035}) begin
      n_fail++;
      $display("FAIL rstx_result: vld0=%b C=%b Z=%b res=%h, required 0/0/0/0035",
               rsp0_valid[1], rsp_flag_c[1], rsp_flag_z[1], rsp_result[1]);
    end
    tick();
  endtask

  initial begin
    clk        = 1'b0;
    rst_n      = 2'b00;
    req0_valid = 2'b00;
    req1_valid = 2'b00;
    rsp0_ready = 2'b11;
    rsp1_ready = 2'b11;
    for (int g = 0; g < 2; g++) begin
      req0_opcode[g] = '0; req0_a[g] = '0; req0_b[g] = '0;
      req1_opcode[g] = '0; req1_a[g] = '0; req1_b[g] = '0;
    end
    test_reset();
    test_add();
    test_contention();
    test_round_robin();
    test_div_zero();
    test_backpressure();
    test_reset_mid_exec();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_drain: %0d responses outstanding, required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
